// File: rtl/cdc_pulse_sync_multi_fin_sout.sv
// N-channel fast->slow pulse synchronizer using toggle req/ack with a 1-deep pending slot.
// Define CDC_DROP_CNT_EN to add the saturating drop_cnt_fast counter.
module cdc_pulse_sync_multi_fin_sout #(
    parameter int NUM_CH      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic              fast_clk,
    input  logic              slow_clk,
    input  logic              reset_n,
    input  logic [NUM_CH-1:0] pulse_in_fast,
    output logic [NUM_CH-1:0] pulse_out_slow,
    output logic [NUM_CH-1:0] busy_fast,
    output logic [NUM_CH-1:0] pend_fast,
    output logic [NUM_CH-1:0] drop_fast
`ifdef CDC_DROP_CNT_EN
    ,
    output logic [CNT_W-1:0]  drop_cnt_fast
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WACK  = 2'd1;
    localparam logic [1:0] S_WPEND = 2'd2;

    logic [NUM_CH-1:0][1:0]             state_q, state_d;
    logic [NUM_CH-1:0]                  tog_q, tog_d;
    logic [NUM_CH-1:0]                  busy_q, busy_d;
    logic [NUM_CH-1:0]                  pend_q, pend_d;
    logic [NUM_CH-1:0]                  drop_q, drop_d;
    logic [SYNC_STAGES-1:0][NUM_CH-1:0] ack_sync_q;
    logic [NUM_CH-1:0]                  ack_w;

    logic [SYNC_STAGES-1:0][NUM_CH-1:0] req_sync_q;
    logic [NUM_CH-1:0]                  edge_q;
    logic [NUM_CH-1:0]                  pulse_q;

    // Handshake complete when the returned ack level matches our request level
    assign ack_w = ~(ack_sync_q[SYNC_STAGES-1] ^ tog_q);

    always_comb begin
        state_d = state_q;
        tog_d   = tog_q;
        drop_d  = '0;
        busy_d  = '0;
        pend_d  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            unique case (state_q[c])
                S_IDLE: begin
                    if (pulse_in_fast[c]) begin
                        tog_d[c]   = ~tog_q[c];
                        state_d[c] = S_WACK;
                    end
                end
                S_WACK: begin
                    if (ack_w[c] && pulse_in_fast[c]) begin
                        tog_d[c] = ~tog_q[c];
                    end else if (ack_w[c]) begin
                        state_d[c] = S_IDLE;
                    end else if (pulse_in_fast[c]) begin
                        state_d[c] = S_WPEND;
                    end
                end
                S_WPEND: begin
                    if (ack_w[c]) begin
                        tog_d[c] = ~tog_q[c];
                        if (!pulse_in_fast[c]) begin
                            state_d[c] = S_WACK;
                        end
                    end else if (pulse_in_fast[c]) begin
                        drop_d[c] = 1'b1;
                    end
                end
                default: state_d[c] = S_IDLE;
            endcase
            busy_d[c] = (state_d[c] != S_IDLE);
            pend_d[c] = (state_d[c] == S_WPEND);
        end
    end

    always_ff @(posedge fast_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= '0;
            tog_q      <= '0;
            busy_q     <= '0;
            pend_q     <= '0;
            drop_q     <= '0;
            ack_sync_q <= '0;
        end else begin
            state_q    <= state_d;
            tog_q      <= tog_d;
            busy_q     <= busy_d;
            pend_q     <= pend_d;
            drop_q     <= drop_d;
            ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], edge_q};
        end
    end

    // The edge flop doubles as the ack source returned to the fast side
    always_ff @(posedge slow_clk or negedge reset_n) begin
        if (!reset_n) begin
            req_sync_q <= '0;
            edge_q     <= '0;
            pulse_q    <= '0;
        end else begin
            req_sync_q <= {req_sync_q[SYNC_STAGES-2:0], tog_q};
            edge_q     <= req_sync_q[SYNC_STAGES-1];
            pulse_q    <= req_sync_q[SYNC_STAGES-1] ^ edge_q;
        end
    end

    assign pulse_out_slow = pulse_q;
    assign busy_fast      = busy_q;
    assign pend_fast      = pend_q;
    assign drop_fast      = drop_q;

`ifdef CDC_DROP_CNT_EN
    localparam int SW = $clog2(NUM_CH + 1);

    logic [SW-1:0]       drop_sum;
    logic [CNT_W+SW-1:0] cnt_sum;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    always_comb begin
        drop_sum = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            drop_sum = drop_sum + SW'(drop_q[c]);
        end
        cnt_sum = {{SW{1'b0}}, cnt_q} + {{CNT_W{1'b0}}, drop_sum};
        cnt_d   = (cnt_sum[CNT_W+SW-1:CNT_W] != '0) ? {CNT_W{1'b1}}
                                                   : cnt_sum[CNT_W-1:0];
    end

    always_ff @(posedge fast_clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign drop_cnt_fast = cnt_q;
`endif

endmodule

// File: tb/tb_cdc_pulse_sync_multi_fin_sout.sv
// Directed bench for cdc_pulse_sync_multi_fin_sout, fast:slow = 5:1.
// Vector table plus hand-written handshake, reset and counter sequences.
module tb_cdc_pulse_sync_multi_fin_sout;

    logic       fast_clk;
    logic       slow_clk;
    logic       reset_n;
    logic [3:0] pulse_in;
    logic [3:0] pulse_out;
    logic [3:0] busy;
    logic [3:0] pend;
    logic [3:0] drop;
`ifdef CDC_DROP_CNT_EN
    logic [1:0] drop_cnt;
`endif

    cdc_pulse_sync_multi_fin_sout #(
        .NUM_CH(4),
        .SYNC_STAGES(2),
        .CNT_W(2)
    ) dut (
        .fast_clk      (fast_clk),
        .slow_clk      (slow_clk),
        .reset_n       (reset_n),
        .pulse_in_fast (pulse_in),
        .pulse_out_slow(pulse_out),
        .busy_fast     (busy),
        .pend_fast     (pend),
        .drop_fast     (drop)
`ifdef CDC_DROP_CNT_EN
        ,
        .drop_cnt_fast (drop_cnt)
`endif
    );

    initial begin
        fast_clk = 1'b0;
        forever #5 fast_clk = ~fast_clk;
    end

    initial begin
        slow_clk = 1'b0;
        #2;
        forever #25 slow_clk = ~slow_clk;
    end

    int n_chk  = 0;
    int n_fail = 0;

    int out_cnt [4];
    int pend_cyc[4];
    int drop_tot;
    int wide_err;
    logic [3:0] prev_out;

    initial begin
        for (int c = 0; c < 4; c++) begin
            out_cnt[c]  = 0;
            pend_cyc[c] = 0;
        end
        drop_tot = 0;
        wide_err = 0;
        prev_out = '0;
    end

    always @(negedge slow_clk) begin
        for (int c = 0; c < 4; c++) begin
            if (pulse_out[c]) begin
                out_cnt[c] = out_cnt[c] + 1;
                if (prev_out[c]) wide_err = wide_err + 1;
            end
        end
        prev_out = pulse_out;
    end

    always @(negedge fast_clk) begin
        for (int c = 0; c < 4; c++) begin
            if (drop[c]) drop_tot = drop_tot + 1;
            if (pend[c]) pend_cyc[c] = pend_cyc[c] + 1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] mask, input int n);
        pulse_in = mask;
        repeat (n) @(posedge fast_clk);
        #1 pulse_in = '0;
    endtask

    task automatic align();
        @(posedge slow_clk);
        @(posedge fast_clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(posedge fast_clk);
            #1;
            if (busy == '0 && pend == '0) done = 1'b1;
        end
        if (!done) chk({name, "_timeout"}, 1, 0);
        repeat (3) @(posedge slow_clk);
        #1;
    endtask

    typedef struct {
        logic [3:0] mask;
        int         npulse;
        int         exp_out[4];
        int         exp_drop;
        logic [3:0] exp_pend;
    } vec_t;

    vec_t vec[5];

    int o0[4];
    int d0;
    int w0;
    int p0[4];
    int n;
    int k;
    bit busy_ok;

    initial begin
        vec[0] = '{4'b0001, 1, '{1, 0, 0, 0}, 0, 4'b0000};
        vec[1] = '{4'b0010, 3, '{0, 2, 0, 0}, 1, 4'b0010};
        vec[2] = '{4'b1111, 1, '{1, 1, 1, 1}, 0, 4'b0000};
        vec[3] = '{4'b0101, 2, '{2, 0, 2, 0}, 0, 4'b0101};
        vec[4] = '{4'b1000, 4, '{0, 0, 0, 2}, 2, 4'b1000};

        pulse_in = '0;
        reset_n  = 1'b0;
        #1;
        chk("reset_outputs", int'({pulse_out, busy, pend, drop}), 0);
        repeat (3) @(posedge fast_clk);
        #1 reset_n = 1'b1;
        repeat (5) @(posedge slow_clk);
        #1;
        chk("post_reset_outputs", int'({pulse_out, busy, pend, drop}), 0);

        // Single pulse latency on ch0
        align();
        o0[0] = out_cnt[0];
        pulse_in = 4'b0001;
        @(posedge fast_clk);
        #1 pulse_in = '0;
        chk("lat_busy_set", int'(busy[0]), 1);
        chk("lat_pend_clr", int'(pend[0]), 0);
        n = 0;
        while (n < 10) begin
            @(posedge slow_clk);
            n++;
            #1;
            if (pulse_out[0]) break;
        end
        chk("lat_slow_edges", n, 3);
        wait_idle("lat");
        chk("lat_out_cnt", out_cnt[0] - o0[0], 1);
        chk("lat_busy_clr", int'(busy[0]), 0);

        // Measure ack return on ch2, then pulse exactly on the ack cycle
        align();
        pulse_in = 4'b0100;
        @(posedge fast_clk);
        #1 pulse_in = '0;
        k = 0;
        while (k < 100) begin
            @(posedge fast_clk);
            k++;
            #1;
            if (!busy[2]) break;
        end
        wait_idle("ackm");
        align();
        o0[2] = out_cnt[2];
        d0 = drop_tot;
        busy_ok = 1'b1;
        pulse_in = 4'b0100;
        @(posedge fast_clk);
        #1 pulse_in = '0;
        repeat (k - 1) begin
            @(posedge fast_clk);
            #1;
            if (!busy[2]) busy_ok = 1'b0;
        end
        pulse_in = 4'b0100;
        @(posedge fast_clk);
        #1 pulse_in = '0;
        chk("ackhit_busy_kept", int'(busy[2] & busy_ok), 1);
        chk("ackhit_no_pend", int'(pend[2]), 0);
        wait_idle("ackhit");
        chk("ackhit_out_cnt", out_cnt[2] - o0[2], 2);
        chk("ackhit_drops", drop_tot - d0, 0);

        for (int v = 0; v < 5; v++) begin
            align();
            for (int c = 0; c < 4; c++) begin
                o0[c] = out_cnt[c];
                p0[c] = pend_cyc[c];
            end
            d0 = drop_tot;
            w0 = wide_err;
            drive(vec[v].mask, vec[v].npulse);
            wait_idle($sformatf("vec%0d", v));
            for (int c = 0; c < 4; c++) begin
                chk($sformatf("vec%0d_out_ch%0d", v, c),
                    out_cnt[c] - o0[c], vec[v].exp_out[c]);
                chk($sformatf("vec%0d_pend_ch%0d", v, c),
                    int'(pend_cyc[c] > p0[c]), int'(vec[v].exp_pend[c]));
            end
            chk($sformatf("vec%0d_drops", v), drop_tot - d0, vec[v].exp_drop);
            chk($sformatf("vec%0d_width", v), wide_err - w0, 0);
            chk($sformatf("vec%0d_busy", v), int'(busy), 0);
        end

        // Reset while ch0 holds a pending event
        align();
        o0[0] = out_cnt[0];
        drive(4'b0001, 2);
        chk("rst_pend_seen", int'(pend[0]), 1);
        reset_n = 1'b0;
        #1;
        chk("rst_outputs_zero", int'({pulse_out, busy, pend, drop}), 0);
        @(posedge fast_clk);
        #1 reset_n = 1'b1;
        repeat (100) @(posedge fast_clk);
        #1;
        chk("rst_no_out", out_cnt[0] - o0[0], 0);
        chk("rst_busy", int'(busy), 0);

`ifdef CDC_DROP_CNT_EN
        chk("cnt_reset", int'(drop_cnt), 0);
        align();
        drive(4'b0001, 3);
        wait_idle("cnt1");
        chk("cnt_one", int'(drop_cnt), 1);
        align();
        d0 = drop_tot;
        drive(4'b1111, 3);
        wait_idle("cnt4");
        chk("cnt_four_drops", drop_tot - d0, 4);
        chk("cnt_saturate", int'(drop_cnt), 3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
